multi_port_load_queue: RTL and testbench
========================================

MULTI_PORT_LOAD_QUEUE -- requirements
Module: multi_port_load_queue

Interface
REQ-001 SHALL have parameter ENTRY_NUM, default 16, entry count, power of two, minimum 4.
REQ-002 SHALL have parameter ALLOC_WIDTH, default 2, allocation lanes per cycle.
REQ-003 SHALL have parameters LOAD_WIDTH, default 2, and STORE_WIDTH, default 1, giving executed load lanes and executed store lanes.
REQ-004 SHALL have parameter RELEASE_WIDTH, default 2, maximum entries released per cycle.
REQ-005 SHALL have parameters BLOCK_ADDR_WIDTH, default 28, WORD_NUM, default 4, and PC_WIDTH, default 32.
REQ-006 SHALL have parameter SNOOP_EN, default 1; when 1, load-load ordering checking by snoop is enabled.
REQ-007 Port clk  in  1  single clock, rising edge.
REQ-008 Port rst  in  1  asynchronous active-low reset; 0 means reset.
REQ-009 Ports allocReq[ALLOC_WIDTH]  in  1 each  allocation request per lane; allocPtr[ALLOC_WIDTH]  out  log2(ENTRY_NUM) each  allocated index per lane.
REQ-010 Port allocatable  out  1  one cycle of full-width allocation is possible; count  out  log2(ENTRY_NUM)+1  number of occupied entries.
REQ-011 Ports releaseNum  in  log2(RELEASE_WIDTH)+1  number of entries to release from head; headPtr  out  log2(ENTRY_NUM)  oldest entry.
REQ-012 Ports recoverValid  in  1  flush request; recoverTailPtr  in  log2(ENTRY_NUM)+1  new tail pointer, including wrap bit.
REQ-013 Per load lane: ldValid, ldPtr, ldBlockAddr, ldWordRE[WORD_NUM], ldRegValid, ldPC, all inputs.
REQ-014 Per store lane: stValid, stLqPtr (index of the oldest load younger than the store), stBlockAddr, stWordWE[WORD_NUM], all inputs.
REQ-015 Ports snoopValid  in  1  and snoopBlockAddr  in  BLOCK_ADDR_WIDTH  describe an external invalidation.
REQ-016 Outputs per store lane: conflict and conflictPC[PC_WIDTH]. Outputs for snoop: llViolation and llPtr.

Function
REQ-017 Head and tail pointers SHALL each carry one wrap bit, so all ENTRY_NUM entries are usable.
 - Full condition: indices equal and wrap bits differ.
 - Empty condition: pointers fully equal.
REQ-018 allocPtr[i] SHALL be tail plus the number of requesting lanes below i, modulo ENTRY_NUM; this output is combinational.
REQ-019 allocatable SHALL equal (count <= ENTRY_NUM - ALLOC_WIDTH).
REQ-020 Each cycle the tail SHALL advance by popcount(allocReq) and the head SHALL advance by releaseNum; both updates take effect at the same edge.
REQ-021 When recoverValid is 1, tail SHALL be set to recoverTailPtr and allocReq SHALL be ignored that cycle; release still applies.
REQ-022 A newly allocated entry SHALL clear finished and snooped at the next edge.
REQ-023 An executed load SHALL store address, wordRE, regValid and PC, and set finished at the next edge.
REQ-024 If a load write and an allocation target the same index in one cycle, the load write SHALL win.
REQ-025 A store match SHALL require all of: entry finished, regValid, block address equal, and (wordRE & wordWE) != 0.
REQ-026 The range searched for a store SHALL run from stLqPtr (inclusive) to tail (exclusive), with circular wrap.
REQ-027 The oldest match in that range SHALL be picked, and its PC SHALL be reported.
REQ-028 A load executing in the same cycle as a store SHALL also be checked.
 - The load matches if its address and word mask overlap the store's, and its age is >= the store's age, with age measured relative to head.
 - A same-cycle load match SHALL override the queued match PC.
REQ-029 conflict and conflictPC SHALL be registered, with exactly 1-cycle latency after stValid; when there is no conflict, conflictPC is 0.
REQ-030 When SNOOP_EN is 1 and snoopValid is 1, every finished entry whose block address matches SHALL set snooped, except the head entry.
REQ-031 In the cycle after a snoop, llViolation SHALL be 1 and llPtr SHALL be the oldest newly-snooped index.
REQ-032 When SNOOP_EN is 0, llViolation and llPtr SHALL be tied to 0.
REQ-033 Entries outside the range [head, tail) SHALL never match.
REQ-034 Assertions SHALL cover the following illegal conditions:
 - releaseNum > count;
 - allocation while full;
 - stLqPtr outside [head, tail].

Reset
REQ-035 While rst is 0, the block SHALL asynchronously clear:
 - head, tail and count to 0;
 - every finished and snooped flag to 0;
 - conflict, conflictPC, llViolation and llPtr to 0.
REQ-036 After reset, allocatable SHALL be 1 and allocPtr[i] SHALL equal i.
REQ-037 Reset asserted mid-operation SHALL discard all in-flight registered results, with no output glitch surviving past deassertion.
REQ-038 Entry payload fields (address, PC, wordRE) SHALL need no reset.

Structure
REQ-039 The entry struct, pointer, count and word-mask typedefs, and the default constants SHALL be defined in the shared LoadStoreUnitTypes package.
REQ-040 One sub-module, lq_oldest_picker, SHALL be used: a circular-range priority picker with inputs headPtr, tailPtr and request[ENTRY_NUM], and outputs grantPtr and picked.
 - One instance per store lane.
 - One instance for snoop, present only when SNOOP_EN is 1.

Verification
REQ-041 Scenario: after reset, allocate 2 per cycle for 8 cycles. Required: count reaches 16, allocatable falls to 0 after cycle 7, and allocPtr wraps from 15 to 0.
REQ-042 Scenario: load at ptr 5 executes with blockAddr 0x40 and wordRE 0001; a store then executes with stLqPtr 3, address 0x40, WE 0011. Required: conflict is 1 one cycle later and conflictPC equals the PC of ptr 5.
REQ-043 Scenario: as REQ-042 but with store WE 0100. Required: conflict is 0. Repeat with stLqPtr 6. Required: conflict is 0.
REQ-044 Scenario: load and store in the same cycle, load ptr 9, store stLqPtr 9, same address. Required: conflict is 1 with the load's PC. Repeat with the load at ptr 8. Required: conflict is 0.
REQ-045 Scenario: head 14, tail 2 with wrap; finished loads at 15 and 1 match a snoop of 0x80. Required: llViolation is 1 and llPtr is 15. Repeat with SNOOP_EN = 0. Required: llViolation stays 0.
REQ-046 Scenario: recoverValid with recoverTailPtr = head + 3 while allocReq = 11. Required: tail equals head + 3 and count equals 3; then assert rst low mid-stream. Required: all outputs are 0 immediately.

Source files
------------

// File: rtl/multi_port_load_queue_pkg.sv
// Shared load/store unit types: default sizes, pointer/count/mask
// typedefs and the load queue entry payload.
package LoadStoreUnitTypes;

    localparam int LQ_ENTRY_NUM        = 16;
    localparam int LQ_ALLOC_WIDTH      = 2;
    localparam int LQ_LOAD_WIDTH       = 2;
    localparam int LQ_STORE_WIDTH      = 1;
    localparam int LQ_RELEASE_WIDTH    = 2;
    localparam int LQ_BLOCK_ADDR_WIDTH = 28;
    localparam int LQ_WORD_NUM         = 4;
    localparam int LQ_PC_WIDTH         = 32;
    localparam bit LQ_SNOOP_EN         = 1'b1;

    localparam int LQ_IDX_W = $clog2(LQ_ENTRY_NUM);

    typedef logic [LQ_IDX_W-1:0]    lq_idx_t;
    typedef logic [LQ_IDX_W:0]      lq_ptr_t;
    typedef logic [LQ_IDX_W:0]      lq_count_t;
    typedef logic [LQ_WORD_NUM-1:0] lq_word_mask_t;

    typedef struct packed {
        logic [LQ_BLOCK_ADDR_WIDTH-1:0] blockAddr;
        lq_word_mask_t                  wordRE;
        logic                           regValid;
        logic [LQ_PC_WIDTH-1:0]         pc;
    } lq_entry_t;

endpackage

// File: rtl/lq_oldest_picker.sv
// Circular-range priority picker: grants the oldest requester in
// [headPtr, tailPtr), pointers carrying one wrap bit.
module lq_oldest_picker #(
    parameter int ENTRY_NUM = 16,
    localparam int IW = $clog2(ENTRY_NUM),
    localparam int PW = IW + 1
) (
    input  logic [PW-1:0]        headPtr,
    input  logic [PW-1:0]        tailPtr,
    input  logic [ENTRY_NUM-1:0] request,
    output logic [IW-1:0]        grantPtr,
    output logic                 picked
);

    logic [PW-1:0] len;
    logic [IW-1:0] idx;

    // Scan youngest to oldest so the last hit is the oldest one.
    always_comb begin
        len      = tailPtr - headPtr;
        grantPtr = '0;
        picked   = 1'b0;
        idx      = '0;
        for (int k = ENTRY_NUM - 1; k >= 0; k--) begin
            idx = headPtr[IW-1:0] + IW'(k);
            if (PW'(k) < len && request[idx]) begin
                grantPtr = idx;
                picked   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/multi_port_load_queue.sv
// Multi-port load queue: circular allocation, store-load conflict
// detection per store lane and snoop-based load-load ordering check.
module multi_port_load_queue
    import LoadStoreUnitTypes::*;
#(
    parameter int ENTRY_NUM        = LQ_ENTRY_NUM,
    parameter int ALLOC_WIDTH      = LQ_ALLOC_WIDTH,
    parameter int LOAD_WIDTH       = LQ_LOAD_WIDTH,
    parameter int STORE_WIDTH      = LQ_STORE_WIDTH,
    parameter int RELEASE_WIDTH    = LQ_RELEASE_WIDTH,
    parameter int BLOCK_ADDR_WIDTH = LQ_BLOCK_ADDR_WIDTH,
    parameter int WORD_NUM         = LQ_WORD_NUM,
    parameter int PC_WIDTH         = LQ_PC_WIDTH,
    parameter bit SNOOP_EN         = LQ_SNOOP_EN,
    localparam int IW = $clog2(ENTRY_NUM),
    localparam int PW = IW + 1,
    localparam int RW = $clog2(RELEASE_WIDTH) + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ALLOC_WIDTH-1:0]      allocReq,
    output logic [IW-1:0]               allocPtr [ALLOC_WIDTH],
    output logic                        allocatable,
    output logic [PW-1:0]               count,
    input  logic [RW-1:0]               releaseNum,
    output logic [IW-1:0]               headPtr,
    input  logic                        recoverValid,
    input  logic [PW-1:0]               recoverTailPtr,
    input  logic [LOAD_WIDTH-1:0]       ldValid,
    input  logic [IW-1:0]               ldPtr [LOAD_WIDTH],
    input  logic [BLOCK_ADDR_WIDTH-1:0] ldBlockAddr [LOAD_WIDTH],
    input  logic [WORD_NUM-1:0]         ldWordRE [LOAD_WIDTH],
    input  logic [LOAD_WIDTH-1:0]       ldRegValid,
    input  logic [PC_WIDTH-1:0]         ldPC [LOAD_WIDTH],
    input  logic [STORE_WIDTH-1:0]      stValid,
    input  logic [IW-1:0]               stLqPtr [STORE_WIDTH],
    input  logic [BLOCK_ADDR_WIDTH-1:0] stBlockAddr [STORE_WIDTH],
    input  logic [WORD_NUM-1:0]         stWordWE [STORE_WIDTH],
    input  logic                        snoopValid,
    input  logic [BLOCK_ADDR_WIDTH-1:0] snoopBlockAddr,
    output logic [STORE_WIDTH-1:0]      conflict,
    output logic [PC_WIDTH-1:0]         conflictPC [STORE_WIDTH],
    output logic                        llViolation,
    output logic [IW-1:0]               llPtr
);

    logic [PW-1:0]        head_q, head_d;
    logic [PW-1:0]        tail_q, tail_d;
    logic [PW-1:0]        allocNum;
    logic [ENTRY_NUM-1:0] finished_q, finished_d;
    logic [ENTRY_NUM-1:0] snooped_q, snooped_d;
    logic [ENTRY_NUM-1:0] inRange;
    logic [ENTRY_NUM-1:0] snoopHit;
    logic [IW-1:0]        off;
    lq_entry_t            entry_q [ENTRY_NUM];

    assign count       = tail_q - head_q;
    assign allocatable = count <= PW'(ENTRY_NUM - ALLOC_WIDTH);
    assign headPtr     = head_q[IW-1:0];

    always_comb begin
        allocNum = '0;
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            allocPtr[i] = tail_q[IW-1:0] + allocNum[IW-1:0];
            allocNum    = allocNum + PW'(allocReq[i]);
        end
    end

    assign head_d = head_q + PW'(releaseNum);
    assign tail_d = recoverValid ? recoverTailPtr : tail_q + allocNum;

    always_comb begin
        inRange  = '0;
        snoopHit = '0;
        off      = '0;
        for (int e = 0; e < ENTRY_NUM; e++) begin
            off         = IW'(e) - head_q[IW-1:0];
            inRange[e]  = {1'b0, off} < count;
            snoopHit[e] = SNOOP_EN && snoopValid && inRange[e]
                        && finished_q[e]
                        && entry_q[e].blockAddr == snoopBlockAddr
                        && IW'(e) != head_q[IW-1:0];
        end
    end

    // Snoop marks first, allocation clears, a load write has the last word.
    always_comb begin
        finished_d = finished_q;
        snooped_d  = snooped_q | snoopHit;
        if (!recoverValid) begin
            for (int i = 0; i < ALLOC_WIDTH; i++) begin
                if (allocReq[i]) begin
                    finished_d[allocPtr[i]] = 1'b0;
                    snooped_d[allocPtr[i]]  = 1'b0;
                end
            end
        end
        for (int l = 0; l < LOAD_WIDTH; l++) begin
            if (ldValid[l]) finished_d[ldPtr[l]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            finished_q <= '0;
            snooped_q  <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            finished_q <= finished_d;
            snooped_q  <= snooped_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int l = 0; l < LOAD_WIDTH; l++) begin
            if (ldValid[l]) begin
                entry_q[ldPtr[l]] <= '{blockAddr: ldBlockAddr[l],
                                       wordRE:    ldWordRE[l],
                                       regValid:  ldRegValid[l],
                                       pc:        ldPC[l]};
            end
        end
    end

    for (genvar s = 0; s < STORE_WIDTH; s++) begin : g_st
        logic [ENTRY_NUM-1:0] req;
        logic [PW-1:0]        stHead;
        logic [IW-1:0]        qPtr, stAge, ldAge, bestAge;
        logic                 qHit, ldHit;
        logic [PC_WIDTH-1:0]  ldHitPC;
        logic                 conflict_q;
        logic [PC_WIDTH-1:0]  conflictPC_q;

        always_comb begin
            req = '0;
            for (int e = 0; e < ENTRY_NUM; e++) begin
                req[e] = inRange[e] && finished_q[e]
                       && entry_q[e].regValid
                       && entry_q[e].blockAddr == stBlockAddr[s]
                       && |(entry_q[e].wordRE & stWordWE[s]);
            end
            stHead = {(stLqPtr[s] >= head_q[IW-1:0]) ? head_q[IW] : ~head_q[IW],
                      stLqPtr[s]};
        end

        lq_oldest_picker #(.ENTRY_NUM(ENTRY_NUM)) u_pick (
            .headPtr (stHead),
            .tailPtr (tail_q),
            .request (req),
            .grantPtr(qPtr),
            .picked  (qHit)
        );

        // Loads executing alongside the store are not in the queue yet.
        always_comb begin
            stAge   = stLqPtr[s] - head_q[IW-1:0];
            ldAge   = '0;
            bestAge = '1;
            ldHit   = 1'b0;
            ldHitPC = '0;
            for (int l = 0; l < LOAD_WIDTH; l++) begin
                ldAge = ldPtr[l] - head_q[IW-1:0];
                if (ldValid[l] && ldBlockAddr[l] == stBlockAddr[s]
                    && |(ldWordRE[l] & stWordWE[s]) && ldAge >= stAge
                    && (!ldHit || ldAge < bestAge)) begin
                    ldHit   = 1'b1;
                    bestAge = ldAge;
                    ldHitPC = ldPC[l];
                end
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                conflict_q   <= 1'b0;
                conflictPC_q <= '0;
            end else begin
                conflict_q   <= stValid[s] && (qHit || ldHit);
                conflictPC_q <= !stValid[s] ? '0
                              : ldHit ? ldHitPC
                              : qHit ? entry_q[qPtr].pc : '0;
            end
        end

        assign conflict[s]   = conflict_q;
        assign conflictPC[s] = conflictPC_q;

`ifndef SYNTHESIS
        always_ff @(posedge clk) begin
            if (rst && stValid[s]) assert ({1'b0, stAge} <= count);
        end
`endif
    end

    if (SNOOP_EN) begin : g_snoop
        logic [IW-1:0] snPtr;
        logic          snHit;
        logic          llViolation_q;
        logic [IW-1:0] llPtr_q;

        lq_oldest_picker #(.ENTRY_NUM(ENTRY_NUM)) u_pick (
            .headPtr (head_q),
            .tailPtr (tail_q),
            .request (snoopHit & ~snooped_q),
            .grantPtr(snPtr),
            .picked  (snHit)
        );

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                llViolation_q <= 1'b0;
                llPtr_q       <= '0;
            end else begin
                llViolation_q <= snHit;
                llPtr_q       <= snHit ? snPtr : '0;
            end
        end

        assign llViolation = llViolation_q;
        assign llPtr       = llPtr_q;
    end else begin : g_no_snoop
        assign llViolation = 1'b0;
        assign llPtr       = '0;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (PW'(releaseNum) <= count);
            assert (!(|allocReq && !recoverValid && count == PW'(ENTRY_NUM)));
        end
    end
`endif

endmodule

// File: tb/tb_multi_port_load_queue.sv
// Scoreboard bench for multi_port_load_queue: a snoop-enabled and a
// snoop-disabled instance share one stimulus stream.
module tb_multi_port_load_queue;
    import LoadStoreUnitTypes::*;

    localparam int IW = LQ_IDX_W;
    localparam int PW = LQ_IDX_W + 1;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic [1:0]  allocReq;
    logic [1:0]  releaseNum;
    logic        recoverValid;
    logic [4:0]  recoverTailPtr;
    logic [1:0]  ldValid;
    logic [3:0]  ldPtr [2];
    logic [27:0] ldBlockAddr [2];
    logic [3:0]  ldWordRE [2];
    logic [1:0]  ldRegValid;
    logic [31:0] ldPC [2];
    logic [0:0]  stValid;
    logic [3:0]  stLqPtr [1];
    logic [27:0] stBlockAddr [1];
    logic [3:0]  stWordWE [1];
    logic        snoopValid;
    logic [27:0] snoopBlockAddr;

    logic [3:0]  allocPtr [2];
    logic        allocatable;
    logic [4:0]  count;
    logic [3:0]  headPtr;
    logic [0:0]  conflict;
    logic [31:0] conflictPC [1];
    logic        llViolation;
    logic [3:0]  llPtr;

    logic [3:0]  n_allocPtr [2];
    logic        n_allocatable;
    logic [4:0]  n_count;
    logic [3:0]  n_headPtr;
    logic [0:0]  n_conflict;
    logic [31:0] n_conflictPC [1];
    logic        n_llViolation;
    logic [3:0]  n_llPtr;

    multi_port_load_queue dut (
        .clk(clk), .rst(rst),
        .allocReq(allocReq), .allocPtr(allocPtr),
        .allocatable(allocatable), .count(count),
        .releaseNum(releaseNum), .headPtr(headPtr),
        .recoverValid(recoverValid), .recoverTailPtr(recoverTailPtr),
        .ldValid(ldValid), .ldPtr(ldPtr), .ldBlockAddr(ldBlockAddr),
        .ldWordRE(ldWordRE), .ldRegValid(ldRegValid), .ldPC(ldPC),
        .stValid(stValid), .stLqPtr(stLqPtr), .stBlockAddr(stBlockAddr),
        .stWordWE(stWordWE),
        .snoopValid(snoopValid), .snoopBlockAddr(snoopBlockAddr),
        .conflict(conflict), .conflictPC(conflictPC),
        .llViolation(llViolation), .llPtr(llPtr)
    );

    multi_port_load_queue #(.SNOOP_EN(1'b0)) dut_ns (
        .clk(clk), .rst(rst),
        .allocReq(allocReq), .allocPtr(n_allocPtr),
        .allocatable(n_allocatable), .count(n_count),
        .releaseNum(releaseNum), .headPtr(n_headPtr),
        .recoverValid(recoverValid), .recoverTailPtr(recoverTailPtr),
        .ldValid(ldValid), .ldPtr(ldPtr), .ldBlockAddr(ldBlockAddr),
        .ldWordRE(ldWordRE), .ldRegValid(ldRegValid), .ldPC(ldPC),
        .stValid(stValid), .stLqPtr(stLqPtr), .stBlockAddr(stBlockAddr),
        .stWordWE(stWordWE),
        .snoopValid(snoopValid), .snoopBlockAddr(snoopBlockAddr),
        .conflict(n_conflict), .conflictPC(n_conflictPC),
        .llViolation(n_llViolation), .llPtr(n_llPtr)
    );

    typedef struct {
        string       tag;
        logic        c;
        logic [31:0] pc;
    } cexp_t;

    typedef struct {
        string      tag;
        logic       v;
        logic [3:0] p;
    } sexp_t;

    cexp_t st_sb [$];
    sexp_t sn_sb [$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pcOf(input int p);
        return 32'h1000_0000 + 32'(p);
    endfunction

    task automatic idle();
        allocReq     = '0;
        releaseNum   = '0;
        recoverValid = 1'b0;
        ldValid      = '0;
        ldRegValid   = '0;
        stValid      = '0;
        snoopValid   = 1'b0;
    endtask

    task automatic ld(input int lane, input logic [3:0] p,
                      input logic [27:0] a, input logic [3:0] re,
                      input logic rv);
        ldValid[lane]     = 1'b1;
        ldPtr[lane]       = p;
        ldBlockAddr[lane] = a;
        ldWordRE[lane]    = re;
        ldRegValid[lane]  = rv;
        ldPC[lane]        = pcOf(int'(p));
    endtask

    task automatic st(input logic [3:0] p, input logic [27:0] a,
                      input logic [3:0] we, input logic c,
                      input logic [31:0] pc, input string tag);
        stValid[0]     = 1'b1;
        stLqPtr[0]     = p;
        stBlockAddr[0] = a;
        stWordWE[0]    = we;
        st_sb.push_back('{tag: tag, c: c, pc: pc});
    endtask

    task automatic drain();
        cexp_t ce;
        sexp_t se;
        while (st_sb.size() > 0) begin
            ce = st_sb.pop_front();
            chk({ce.tag, ".c"}, 64'(conflict[0]), 64'(ce.c));
            chk({ce.tag, ".pc"}, 64'(conflictPC[0]), 64'(ce.pc));
            chk({ce.tag, ".ns_c"}, 64'(n_conflict[0]), 64'(ce.c));
            chk({ce.tag, ".ns_pc"}, 64'(n_conflictPC[0]), 64'(ce.pc));
        end
        while (sn_sb.size() > 0) begin
            se = sn_sb.pop_front();
            chk({se.tag, ".llv"}, 64'(llViolation), 64'(se.v));
            chk({se.tag, ".llp"}, 64'(llPtr), 64'(se.p));
            chk({se.tag, ".ns_llv"}, 64'(n_llViolation), 64'(0));
            chk({se.tag, ".ns_llp"}, 64'(n_llPtr), 64'(0));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
        drain();
    endtask

    initial begin
        rst = 1'b0;
        idle();
        recoverTailPtr = '0;
        snoopBlockAddr = '0;
        for (int i = 0; i < 2; i++) begin
            ldPtr[i] = '0; ldBlockAddr[i] = '0; ldWordRE[i] = '0; ldPC[i] = '0;
        end
        stLqPtr[0] = '0; stBlockAddr[0] = '0; stWordWE[0] = '0;
        repeat (2) @(posedge clk);
        #1;
        allocReq = 2'b11;
        #1;
        chk("rst.count", 64'(count), 64'(0));
        chk("rst.head", 64'(headPtr), 64'(0));
        chk("rst.alloc_ok", 64'(allocatable), 64'(1));
        chk("rst.ptr0", 64'(allocPtr[0]), 64'(0));
        chk("rst.ptr1", 64'(allocPtr[1]), 64'(1));
        chk("rst.ns_ptr1", 64'(n_allocPtr[1]), 64'(1));
        chk("rst.conflict", 64'(conflict[0]), 64'(0));
        chk("rst.cpc", 64'(conflictPC[0]), 64'(0));
        chk("rst.llv", 64'(llViolation), 64'(0));
        chk("rst.llp", 64'(llPtr), 64'(0));
        idle();
        rst = 1'b1;

        for (int c = 0; c < 8; c++) begin
            allocReq = 2'b11;
            #1;
            chk($sformatf("fill%0d.count", c), 64'(count), 64'(2 * c));
            chk($sformatf("fill%0d.ptr0", c), 64'(allocPtr[0]), 64'((2 * c) % 16));
            chk($sformatf("fill%0d.ptr1", c), 64'(allocPtr[1]), 64'((2 * c + 1) % 16));
            chk($sformatf("fill%0d.ok", c), 64'(allocatable), 64'(2 * c <= 14));
            step();
        end
        chk("full.count", 64'(count), 64'(16));
        chk("full.ns_count", 64'(n_count), 64'(16));
        chk("full.ok", 64'(allocatable), 64'(0));
        chk("full.ns_ok", 64'(n_allocatable), 64'(0));
        chk("full.ptr_wrap", 64'(allocPtr[0]), 64'(0));

        ld(0, 4'd5, 28'h40, 4'b0001, 1'b1);
        ld(1, 4'd7, 28'h40, 4'b0010, 1'b1);
        step();
        ld(0, 4'd10, 28'h40, 4'b0001, 1'b0);
        step();
        st(4'd3, 28'h40, 4'b0011, 1'b1, pcOf(5), "q_old");
        step();
        st(4'd3, 28'h40, 4'b0100, 1'b0, 32'h0, "q_nowe");
        step();
        st(4'd6, 28'h40, 4'b0001, 1'b0, 32'h0, "q_p6");
        step();
        st(4'd6, 28'h40, 4'b0010, 1'b1, pcOf(7), "q_p6b");
        step();
        st(4'd8, 28'h40, 4'b0001, 1'b0, 32'h0, "q_regv");
        step();
        st(4'd3, 28'h41, 4'b0011, 1'b0, 32'h0, "q_addr");
        step();

        ld(0, 4'd8, 28'h40, 4'b0001, 1'b1);
        st(4'd9, 28'h40, 4'b0001, 1'b0, 32'h0, "sc_older");
        step();
        ld(0, 4'd9, 28'h40, 4'b0001, 1'b1);
        st(4'd9, 28'h40, 4'b0001, 1'b1, pcOf(9), "sc_same");
        step();
        ld(0, 4'd11, 28'h40, 4'b0001, 1'b1);
        st(4'd9, 28'h40, 4'b0001, 1'b1, pcOf(11), "sc_override");
        step();

        releaseNum = 2'd2;
        step();
        for (int c = 0; c < 6; c++) begin
            releaseNum = 2'd2;
            if (c == 0) allocReq = 2'b11;
            step();
        end
        chk("wrap.head", 64'(headPtr), 64'(14));
        chk("wrap.ns_head", 64'(n_headPtr), 64'(14));
        chk("wrap.count", 64'(count), 64'(4));

        ld(0, 4'd15, 28'h80, 4'b1111, 1'b1);
        ld(1, 4'd1, 28'h80, 4'b1111, 1'b1);
        step();
        ld(0, 4'd14, 28'h80, 4'b1111, 1'b1);
        step();
        snoopValid     = 1'b1;
        snoopBlockAddr = 28'h80;
        sn_sb.push_back('{tag: "snoop", v: 1'b1, p: 4'd15});
        step();
        sn_sb.push_back('{tag: "snoop_idle", v: 1'b0, p: 4'd0});
        step();

        st(4'd15, 28'h80, 4'b1111, 1'b1, pcOf(15), "w_15");
        step();
        st(4'd0, 28'h80, 4'b1111, 1'b1, pcOf(1), "w_0");
        step();

        recoverValid   = 1'b1;
        recoverTailPtr = 5'b10001;
        allocReq       = 2'b11;
        step();
        chk("rec.count", 64'(count), 64'(3));
        chk("rec.ns_count", 64'(n_count), 64'(3));
        chk("rec.tail", 64'(allocPtr[0]), 64'(1));

        st(4'd15, 28'h80, 4'b1111, 1'b1, pcOf(15), "pre_rst");
        step();
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst.conflict", 64'(conflict[0]), 64'(0));
        chk("mid_rst.cpc", 64'(conflictPC[0]), 64'(0));
        chk("mid_rst.llv", 64'(llViolation), 64'(0));
        chk("mid_rst.llp", 64'(llPtr), 64'(0));
        chk("mid_rst.count", 64'(count), 64'(0));
        chk("mid_rst.head", 64'(headPtr), 64'(0));
        chk("mid_rst.ns_conflict", 64'(n_conflict[0]), 64'(0));
        #1;
        rst = 1'b1;
        step();
        chk("post_rst.conflict", 64'(conflict[0]), 64'(0));
        chk("post_rst.count", 64'(count), 64'(0));
        chk("post_rst.ok", 64'(allocatable), 64'(1));
        chk("sb.left", 64'(st_sb.size() + sn_sb.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
